// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream width-conversion blocks.
package stream_pkg;

  localparam int unsigned T_DATA_RATIO_DEF = 2;
  localparam int unsigned LANE_IDX_W = $clog2(T_DATA_RATIO_DEF);

  typedef logic [T_DATA_RATIO_DEF-1:0] lane_mask_t;

  // Index width that stays legal when only one lane exists.
  function automatic int unsigned lane_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lsb_onehot.sv
// Lowest-set-bit finder: one-hot of the lowest set bit plus its binary index.
module lsb_onehot
  import stream_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = lane_idx_w(N)
) (
  input  logic [N-1:0]    vec_i,
  output logic [N-1:0]    onehot_o,
  output logic [IdxW-1:0] idx_o
);

  logic found;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (vec_i[i] && !found) begin
        onehot_o[i] = 1'b1;
        idx_o       = IdxW'(i);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits each kept lane of a wide beat, lane 0 first.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 4,
  parameter int unsigned T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int unsigned IdxW = lane_idx_w(T_DATA_RATIO);

  typedef logic [T_DATA_RATIO-1:0] mask_t;

  logic [T_DATA_WIDTH-1:0] buf_q [T_DATA_RATIO];
  mask_t                   rem_q;
  logic                    last_q;

  mask_t                   cur;
  logic [IdxW-1:0]         cur_idx;
  logic                    on_final_lane;
  logic                    pop;
  logic                    acc;

  lsb_onehot #(
    .N    (T_DATA_RATIO),
    .IdxW (IdxW)
  ) u_lsb (
    .vec_i    (rem_q),
    .onehot_o (cur),
    .idx_o    (cur_idx)
  );

  assign on_final_lane = (rem_q == cur);

  assign m_valid_o = |rem_q;
  assign m_data_o  = buf_q[cur_idx];
  // Gated by valid so a stale last_q never shows while idle.
  assign m_last_o  = last_q & m_valid_o & on_final_lane;

  // A new wide beat may land on the same edge that drains the final lane.
  assign s_ready_o = (rem_q == '0) | (m_ready_i & on_final_lane);

  assign pop = m_valid_o & m_ready_i;
  assign acc = s_valid_i & s_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      last_q <= 1'b0;
    end else if (acc) begin
      rem_q  <= s_keep_i;
      last_q <= s_last_i;
    end else if (pop) begin
      rem_q  <= rem_q & ~cur;
    end
  end

  // Data buffer is qualified by rem_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (acc) begin
      buf_q <= s_data_i;
    end
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Directed and scoreboarded checks for stream_downsize at lane ratios 2 and 4.
module tb_stream_downsize;

  logic clk;
  logic rst;

  // Ratio-2 instance
  logic [3:0] s_data2 [2];
  logic [1:0] s_keep2;
  logic       s_last2, s_valid2, s_ready2;
  logic [3:0] m_data2;
  logic       m_last2, m_valid2, m_ready2;

  // Ratio-4 instance
  logic [3:0] s_data4 [4];
  logic [3:0] s_keep4;
  logic       s_last4, s_valid4, s_ready4;
  logic [3:0] m_data4;
  logic       m_last4, m_valid4, m_ready4;

  int total = 0;
  int bad   = 0;

  logic [4:0] sb [$];
  logic       drv_done;

  stream_downsize #(
    .T_DATA_WIDTH (4),
    .T_DATA_RATIO (2)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (s_data2),
    .s_keep_i  (s_keep2),
    .s_last_i  (s_last2),
    .s_valid_i (s_valid2),
    .s_ready_o (s_ready2),
    .m_data_o  (m_data2),
    .m_last_o  (m_last2),
    .m_valid_o (m_valid2),
    .m_ready_i (m_ready2)
  );

  stream_downsize #(
    .T_DATA_WIDTH (4),
    .T_DATA_RATIO (4)
  ) dut4 (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (s_data4),
    .s_keep_i  (s_keep4),
    .s_last_i  (s_last4),
    .s_valid_i (s_valid4),
    .s_ready_o (s_ready4),
    .m_data_o  (m_data4),
    .m_last_o  (m_last4),
    .m_valid_o (m_valid4),
    .m_ready_i (m_ready4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect2(input string tag, input logic [3:0] d, input logic l);
    check({tag, ".valid"}, 32'(m_valid2), 32'd1);
    check({tag, ".data"},  32'(m_data2),  32'(d));
    check({tag, ".last"},  32'(m_last2),  32'(l));
  endtask

  task automatic drive2(input logic [3:0] d0, input logic [3:0] d1, input logic [1:0] k,
                        input logic l);
    s_data2[0] = d0;
    s_data2[1] = d1;
    s_keep2    = k;
    s_last2    = l;
    s_valid2   = 1'b1;
  endtask

  task automatic rand_driver();
    int unsigned nb;
    logic [3:0]  d0, d1;
    logic [1:0]  k;
    logic        l, a;
    int          guard;
    for (int p = 0; p < 200; p++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < int'(nb); b++) begin
        l  = (b == int'(nb) - 1);
        k  = l ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
        d0 = 4'($urandom_range(0, 15));
        d1 = 4'($urandom_range(0, 15));
        if (k[0]) sb.push_back({l & ~k[1], d0});
        if (k[1]) sb.push_back({l, d1});
        drive2(d0, d1, k, l);
        guard = 0;
        do begin
          @(negedge clk);
          a = s_ready2;
          @(posedge clk);
          #1;
          guard++;
        end while (!a && guard < 1000);
        check("rand.accept_bound", 32'(a), 32'd1);
        s_valid2 = 1'b0;
      end
    end
    drv_done = 1'b1;
  endtask

  task automatic rand_monitor();
    int         cyc = 0;
    logic       hold = 1'b0;
    logic [3:0] hd;
    logic       hl;
    logic [4:0] e;
    while ((!drv_done || sb.size() != 0) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        check("hold.valid", 32'(m_valid2), 32'd1);
        check("hold.data",  32'(m_data2),  32'(hd));
        check("hold.last",  32'(m_last2),  32'(hl));
      end
      if (m_valid2 && m_ready2) begin
        check("rand.sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rand.data", 32'(m_data2), 32'(e[3:0]));
          check("rand.last", 32'(m_last2), 32'(e[4]));
        end
        hold = 1'b0;
      end else if (m_valid2) begin
        hold = 1'b1;
        hd   = m_data2;
        hl   = m_last2;
      end else begin
        hold = 1'b0;
      end
      @(posedge clk);
      #1;
      m_ready2 = 1'($urandom_range(0, 1));
    end
    check("rand.timeout", 32'(cyc < 30000), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    drv_done = 1'b0;
    s_data2  = '{default: 4'h0};
    s_keep2  = '0;
    s_last2  = 1'b0;
    s_valid2 = 1'b0;
    m_ready2 = 1'b1;
    s_data4  = '{default: 4'h0};
    s_keep4  = '0;
    s_last4  = 1'b0;
    s_valid4 = 1'b0;
    m_ready4 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset.valid", 32'(m_valid2), 32'd0);
    check("reset.last",  32'(m_last2),  32'd0);
    check("reset.ready", 32'(s_ready2), 32'd1);
    check("reset4.valid", 32'(m_valid4), 32'd0);

    // Single full beat with last
    drive2(4'hA, 4'hB, 2'b11, 1'b1);
    tick();
    s_valid2 = 1'b0;
    expect2("t1.a", 4'hA, 1'b0);
    tick();
    expect2("t1.b", 4'hB, 1'b1);
    tick();
    check("t1.idle", 32'(m_valid2), 32'd0);

    // Back-to-back wide beats, no bubble
    drive2(4'h1, 4'h2, 2'b11, 1'b0);
    tick();
    expect2("t2.1", 4'h1, 1'b0);
    drive2(4'h3, 4'h4, 2'b11, 1'b1);
    #1;
    check("t2.ready_busy", 32'(s_ready2), 32'd0);
    tick();
    expect2("t2.2", 4'h2, 1'b0);
    check("t2.ready_final", 32'(s_ready2), 32'd1);
    tick();
    s_valid2 = 1'b0;
    expect2("t2.3", 4'h3, 1'b0);
    tick();
    expect2("t2.4", 4'h4, 1'b1);
    tick();
    check("t2.idle", 32'(m_valid2), 32'd0);

    // Sparse keep on the ratio-4 instance
    s_data4[0] = 4'h8;
    s_data4[1] = 4'h9;
    s_data4[2] = 4'hA;
    s_data4[3] = 4'hB;
    s_keep4    = 4'b1010;
    s_last4    = 1'b1;
    s_valid4   = 1'b1;
    tick();
    s_valid4 = 1'b0;
    check("t3.valid1", 32'(m_valid4), 32'd1);
    check("t3.data1",  32'(m_data4),  32'h9);
    check("t3.last1",  32'(m_last4),  32'd0);
    tick();
    check("t3.valid3", 32'(m_valid4), 32'd1);
    check("t3.data3",  32'(m_data4),  32'hB);
    check("t3.last3",  32'(m_last4),  32'd1);
    tick();
    check("t3.idle", 32'(m_valid4), 32'd0);

    // Stall: outputs hold and upstream is blocked
    m_ready2 = 1'b0;
    drive2(4'h9, 4'h5, 2'b11, 1'b1);
    tick();
    s_valid2 = 1'b0;
    #1;
    expect2("stall.first", 4'h9, 1'b0);
    check("stall.ready", 32'(s_ready2), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect2("stall.hold", 4'h9, 1'b0);
      check("stall.hold_ready", 32'(s_ready2), 32'd0);
    end
    m_ready2 = 1'b1;
    #1;
    check("stall.ready_two_left", 32'(s_ready2), 32'd0);
    tick();
    expect2("stall.second", 4'h5, 1'b1);
    check("stall.ready_final", 32'(s_ready2), 32'd1);
    tick();
    check("stall.idle", 32'(m_valid2), 32'd0);

    // keep=0 beat between packets
    drive2(4'hE, 4'hF, 2'b00, 1'b0);
    #1;
    check("t5.ready", 32'(s_ready2), 32'd1);
    tick();
    drive2(4'h7, 4'h8, 2'b11, 1'b1);
    #1;
    check("t5.no_output", 32'(m_valid2), 32'd0);
    check("t5.ready_after", 32'(s_ready2), 32'd1);
    tick();
    s_valid2 = 1'b0;
    expect2("t5.7", 4'h7, 1'b0);
    tick();
    expect2("t5.8", 4'h8, 1'b1);
    tick();
    check("t5.idle", 32'(m_valid2), 32'd0);

    // Reset mid-packet
    drive2(4'hC, 4'hD, 2'b11, 1'b1);
    tick();
    s_valid2 = 1'b0;
    expect2("t6.c", 4'hC, 1'b0);
    tick();
    expect2("t6.d", 4'hD, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6.valid", 32'(m_valid2), 32'd0);
    check("t6.last",  32'(m_last2),  32'd0);
    check("t6.ready", 32'(s_ready2), 32'd1);
    drive2(4'h5, 4'h6, 2'b11, 1'b1);
    tick();
    s_valid2 = 1'b0;
    expect2("t6.5", 4'h5, 1'b0);
    tick();
    expect2("t6.6", 4'h6, 1'b1);
    tick();
    check("t6.idle", 32'(m_valid2), 32'd0);

    // Random packets against a scoreboard with 50% backpressure
    fork
      rand_driver();
      rand_monitor();
    join
    check("rand.sb_left", 32'(sb.size()), 32'd0);
    m_ready2 = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
